// File: rtl/rsa_exp_ctrl_if.sv
// ============================================================================
//  Module   : rsa_exp_ctrl_if
//  Purpose  : Bundles the host handshake (start/busy/done/result) and the
//             PreProcess / Montgomery-multiplier handshakes of rsa_exp_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
//  The controller owns the "master" view because it sequences both datapath
//  units.  The environment (host plus datapath units) uses the "slave" view.
`default_nettype none

interface rsa_exp_ctrl_if #(
  parameter int WIDTH = 256
);
  // Host side
  logic             start;
  logic [WIDTH-1:0] N_i;
  logic [WIDTH-1:0] y_i;
  logic [WIDTH-1:0] d_i;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  // PreProcess unit
  logic             pp_start;
  logic [WIDTH-1:0] pp_M;
  logic [WIDTH-1:0] pp_N;
  logic             pp_finish;
  logic [WIDTH-1:0] pp_T;

  // Montgomery multiplier
  logic             mm_start;
  logic [WIDTH-1:0] mm_a;
  logic [WIDTH-1:0] mm_b;
  logic [WIDTH-1:0] mm_N;
  logic             mm_finish;
  logic [WIDTH-1:0] mm_res;

  modport master (
    input  start, N_i, y_i, d_i,
    output busy, done, result,
    output pp_start, pp_M, pp_N,
    input  pp_finish, pp_T,
    output mm_start, mm_a, mm_b, mm_N,
    input  mm_finish, mm_res
  );

  modport slave (
    output start, N_i, y_i, d_i,
    input  busy, done, result,
    input  pp_start, pp_M, pp_N,
    output pp_finish, pp_T,
    input  mm_start, mm_a, mm_b, mm_N,
    output mm_finish, mm_res
  );
endinterface

`default_nettype wire

// File: rtl/rsa_exp_ctrl.sv
// ============================================================================
//  Module   : rsa_exp_ctrl
//  Purpose  : Sequencer for y^d mod N.  Issues one PreProcess job
//             (T = y*2^WIDTH mod N), then runs right-to-left
//             square-and-multiply on a shared Montgomery multiplier.
//             m stays in the ordinary domain (starts at 1) while t stays in
//             the Montgomery domain, so m*t*2^-WIDTH keeps m ordinary and the
//             final m is the plain result.
//  Config   : define RSA_EXP_EARLY_EXIT_EN to stop after the highest set
//             bit of d (d==0 then finishes straight from PREP with result 1).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rsa_exp_ctrl #(
  parameter int WIDTH = 256,
  parameter int CNT_W = 9
) (
  input  logic           clk,
  input  logic           rst,
  rsa_exp_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_MUL  = 3'd2,
    S_SQR  = 3'd3,
    S_NEXT = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] d_q, d_d;        // shifted right once per iteration
  logic [WIDTH-1:0] m_q, m_d;        // running product, ordinary domain
  logic [WIDTH-1:0] t_q, t_d;        // running power, Montgomery domain
  logic [WIDTH-1:0] a_q, a_d;        // multiplier operand A
  logic [WIDTH-1:0] b_q, b_d;        // multiplier operand B
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] i_q, i_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pp_start_q, pp_start_d;
  logic             mm_start_q, mm_start_d;

  logic             go_mul;
  logic             go_sqr;
  logic             go_done;
  logic             last_iter;
  logic [WIDTH-1:0] t_src;           // value of t as seen by the next operation

`ifdef RSA_EXP_EARLY_EXIT_EN
  logic [CNT_W-1:0] msb_q, msb_d;
  logic [CNT_W-1:0] msb_w;

  // Index of the highest set bit of the incoming exponent (0 when d==0)
  always_comb begin
    msb_w = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (bus.d_i[k]) msb_w = CNT_W'(k);
    end
  end

  assign last_iter = (i_q == LAST_IDX) || (i_q == msb_q);
`else
  assign last_iter = (i_q == LAST_IDX);
`endif

  // Next-state, operand selection and handshake generation
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    y_d        = y_q;
    d_d        = d_q;
    m_d        = m_q;
    t_d        = t_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    i_d        = i_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pp_start_d = 1'b0;
    mm_start_d = 1'b0;
    go_mul     = 1'b0;
    go_sqr     = 1'b0;
    go_done    = 1'b0;
    t_src      = t_q;
`ifdef RSA_EXP_EARLY_EXIT_EN
    msb_d      = msb_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          n_d        = bus.N_i;
          y_d        = bus.y_i;
          d_d        = bus.d_i;
          m_d        = ONE;
          i_d        = '0;
          busy_d     = 1'b1;
          pp_start_d = 1'b1;
          state_d    = S_PREP;
`ifdef RSA_EXP_EARLY_EXIT_EN
          msb_d      = msb_w;
`endif
        end
      end

      // A finish coincident with our own start pulse is illegal; ignoring it
      // also keeps a stale finish from a reset-aborted job harmless.
      S_PREP: begin
        if (bus.pp_finish && !pp_start_q) begin
          t_d   = bus.pp_T;
          t_src = bus.pp_T;
          if (d_q[0]) go_mul = 1'b1;
          else        go_sqr = 1'b1;
`ifdef RSA_EXP_EARLY_EXIT_EN
          if (d_q == '0) begin
            go_sqr  = 1'b0;
            go_done = 1'b1;
          end
`endif
        end
      end

      S_MUL: begin
        if (bus.mm_finish && !mm_start_q) begin
          m_d    = bus.mm_res;
          go_sqr = 1'b1;
        end
      end

      // The last square is still performed even though its value is unused
      S_SQR: begin
        if (bus.mm_finish && !mm_start_q) begin
          t_d     = bus.mm_res;
          state_d = S_NEXT;
        end
      end

      S_NEXT: begin
        i_d = i_q + CNT_W'(1);
        d_d = d_q >> 1;
        if (last_iter)   go_done = 1'b1;
        else if (d_q[1]) go_mul  = 1'b1;
        else             go_sqr  = 1'b1;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Operands are registered together with the start pulse and then held
    if (go_mul) begin
      state_d    = S_MUL;
      mm_start_d = 1'b1;
      a_d        = m_q;
      b_d        = t_src;
    end
    if (go_sqr) begin
      state_d    = S_SQR;
      mm_start_d = 1'b1;
      a_d        = t_src;
      b_d        = t_src;
    end
    if (go_done) begin
      state_d  = S_DONE;
      done_d   = 1'b1;
      busy_d   = 1'b0;
      result_d = m_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      y_q        <= '0;
      d_q        <= '0;
      m_q        <= '0;
      t_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      i_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pp_start_q <= 1'b0;
      mm_start_q <= 1'b0;
`ifdef RSA_EXP_EARLY_EXIT_EN
      msb_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      y_q        <= y_d;
      d_q        <= d_d;
      m_q        <= m_d;
      t_q        <= t_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      i_q        <= i_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pp_start_q <= pp_start_d;
      mm_start_q <= mm_start_d;
`ifdef RSA_EXP_EARLY_EXIT_EN
      msb_q      <= msb_d;
`endif
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.pp_start = pp_start_q;
  assign bus.pp_M     = y_q;
  assign bus.pp_N     = n_q;
  assign bus.mm_start = mm_start_q;
  assign bus.mm_a     = a_q;
  assign bus.mm_b     = b_q;
  assign bus.mm_N     = n_q;

endmodule

`default_nettype wire

// File: tb/tb_rsa_exp_ctrl.sv
// ============================================================================
//  Module   : tb_rsa_exp_ctrl
//  Purpose  : Self-checking bench for rsa_exp_ctrl with behavioural
//             PreProcess and Montgomery-multiplier models.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rsa_exp_ctrl;
  localparam int WIDTH = 256;
  localparam int CNT_W = 9;

`ifdef RSA_EXP_EARLY_EXIT_EN
  localparam int EXP_MM_D7 = 6;    // popcount 3 + squares up to bit 2
  localparam int EXP_MM_D1 = 2;
  localparam int EXP_MM_D0 = 0;
`else
  localparam int EXP_MM_D7 = 259;  // 256 squares + 3 multiplies
  localparam int EXP_MM_D1 = 257;
  localparam int EXP_MM_D0 = 256;
`endif

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  rsa_exp_ctrl_if #(.WIDTH(WIDTH)) bus ();

  rsa_exp_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural datapath units ----------------
  logic             pp_fin_m   = 1'b0;
  logic             mm_fin_m   = 1'b0;
  logic             mm_fin_inj = 1'b0;
  logic [WIDTH-1:0] pp_res_m   = '0;
  logic [WIDTH-1:0] mm_res_m   = '0;
  logic [WIDTH-1:0] mm_res_inj = {WIDTH{1'b1}};
  int pp_cd = 0, mm_cd = 0, lat_max = 20, n_mm = 0, n_pp = 0;

  assign bus.pp_finish = pp_fin_m;
  assign bus.pp_T      = pp_res_m;
  assign bus.mm_finish = mm_fin_m | mm_fin_inj;
  assign bus.mm_res    = mm_fin_inj ? mm_res_inj : mm_res_m;

  function automatic logic [WIDTH-1:0] mont(input logic [WIDTH-1:0] a, b, n);
    logic [WIDTH+1:0] s;
    s = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (a[k]) s = s + {2'b00, b};
      if (s[0]) s = s + {2'b00, n};
      s = s >> 1;
    end
    if (s >= {2'b00, n}) s = s - {2'b00, n};
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] pre_proc(input logic [WIDTH-1:0] y, n);
    logic [WIDTH:0] r;
    r = {1'b0, y};
    for (int k = 0; k < WIDTH; k++) begin
      r = r << 1;
      if (r >= {1'b0, n}) r = r - {1'b0, n};
    end
    return r[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] mulmod(input logic [WIDTH-1:0] a, b, n);
    logic [WIDTH:0] r;
    r = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      r = r << 1;
      if (r >= {1'b0, n}) r = r - {1'b0, n};
      if (b[k]) begin
        r = r + {1'b0, a};
        if (r >= {1'b0, n}) r = r - {1'b0, n};
      end
    end
    return r[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] modexp(input logic [WIDTH-1:0] y, d, n);
    logic [WIDTH-1:0] r, base;
    r    = {{(WIDTH-1){1'b0}}, 1'b1};
    base = y;
    for (int k = 0; k < WIDTH; k++) begin
      if (d[k]) r = mulmod(r, base, n);
      base = mulmod(base, base, n);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    pp_fin_m = 1'b0;
    mm_fin_m = 1'b0;
    if (pp_cd > 0) begin
      pp_cd--;
      if (pp_cd == 0) pp_fin_m = 1'b1;
    end
    if (mm_cd > 0) begin
      mm_cd--;
      if (mm_cd == 0) mm_fin_m = 1'b1;
    end
    if (bus.pp_start === 1'b1) begin
      n_pp++;
      pp_res_m = pre_proc(bus.pp_M, bus.pp_N);
      pp_cd    = int'($urandom_range(lat_max, 3));
    end
    if (bus.mm_start === 1'b1) begin
      n_mm++;
      mm_res_m = mont(bus.mm_a, bus.mm_b, bus.mm_N);
      mm_cd    = int'($urandom_range(lat_max, 3));
    end
  end

  // Global guard against a hung design
  initial begin
    repeat (400000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle limit");
    $fatal(1, "watchdog");
  end

  // ---------------- run helper (no comparisons inside) ----------------
  task automatic do_run(input logic [WIDTH-1:0] n, y, d, input int lat,
                        input int restart_at, input int spur_at,
                        output logic [WIDTH-1:0] res, output bit tmo,
                        output bit busy_drop, output bit busy_at_done,
                        output int ndone);
    int bound;
    bound        = 520 * (lat + 4) + 100;
    lat_max      = lat;
    tmo          = 1'b1;
    busy_drop    = 1'b0;
    busy_at_done = 1'b1;
    ndone        = 0;
    res          = '0;
    @(negedge clk);
    bus.N_i   = n;
    bus.y_i   = y;
    bus.d_i   = d;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < bound; c++) begin
      mm_fin_inj = (c == spur_at);
      if (c == restart_at) begin
        bus.N_i   = 35;
        bus.y_i   = 3;
        bus.d_i   = 2;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        ndone++;
        res          = bus.result;
        busy_at_done = bus.busy;
        tmo          = 1'b0;
        break;
      end
      if (bus.busy !== 1'b1) busy_drop = 1'b1;
      @(negedge clk);
    end
    mm_fin_inj = 1'b0;
    bus.start  = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.N_i   = '0;
    bus.y_i   = '0;
    bus.d_i   = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.result !== '0) begin failures++; $display("FAIL reset_result: got %0h expected 0", bus.result); end
    checks++; if (bus.pp_start !== 1'b0) begin failures++; $display("FAIL reset_pp_start: got %b expected 0", bus.pp_start); end
    checks++; if (bus.mm_start !== 1'b0) begin failures++; $display("FAIL reset_mm_start: got %b expected 0", bus.mm_start); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] res; bit tmo, bd, bad; int nd;
    n_mm = 0; n_pp = 0;
    do_run(33, 2, 7, 20, -1, -1, res, tmo, bd, bad, nd);
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL basic_timeout: got %b expected 0", tmo); end
    checks++; if (res !== WIDTH'(29)) begin failures++; $display("FAIL basic_result: got %0h expected 1d", res); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL basic_done_count: got %0d expected 1", nd); end
    checks++; if (bd !== 1'b0) begin failures++; $display("FAIL basic_busy_drop: got %b expected 0", bd); end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done: got %b expected 0", bad); end
    checks++; if (n_mm !== EXP_MM_D7) begin failures++; $display("FAIL basic_mm_count: got %0d expected %0d", n_mm, EXP_MM_D7); end
    checks++; if (n_pp !== 1) begin failures++; $display("FAIL basic_pp_count: got %0d expected 1", n_pp); end
    checks++; if (bus.result !== WIDTH'(29)) begin failures++; $display("FAIL basic_result_held: got %0h expected 1d", bus.result); end
  endtask

  task automatic test_exponents();
    logic [WIDTH-1:0] res; bit tmo, bd, bad; int nd;
    n_mm = 0;
    do_run(33, 5, 1, 6, -1, -1, res, tmo, bd, bad, nd);
    checks++; if (res !== WIDTH'(5)) begin failures++; $display("FAIL d1_result: got %0h expected 5", res); end
    checks++; if (n_mm !== EXP_MM_D1) begin failures++; $display("FAIL d1_mm_count: got %0d expected %0d", n_mm, EXP_MM_D1); end
    n_mm = 0;
    do_run(33, 5, 0, 6, -1, -1, res, tmo, bd, bad, nd);
    checks++; if (res !== WIDTH'(1)) begin failures++; $display("FAIL d0_result: got %0h expected 1", res); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL d0_done_count: got %0d expected 1", nd); end
    checks++; if (n_mm !== EXP_MM_D0) begin failures++; $display("FAIL d0_mm_count: got %0d expected %0d", n_mm, EXP_MM_D0); end
    do_run(33, 0, 5, 6, -1, -1, res, tmo, bd, bad, nd);
    checks++; if (res !== WIDTH'(0)) begin failures++; $display("FAIL y0_result: got %0h expected 0", res); end
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL y0_timeout: got %b expected 0", tmo); end
  endtask

  task automatic test_restart_ignored();
    logic [WIDTH-1:0] res; bit tmo, bd, bad; int nd;
    do_run(33, 2, 7, 6, 100, -1, res, tmo, bd, bad, nd);
    checks++; if (res !== WIDTH'(29)) begin failures++; $display("FAIL restart_result: got %0h expected 1d", res); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL restart_done_count: got %0d expected 1", nd); end
    checks++; if (bd !== 1'b0) begin failures++; $display("FAIL restart_busy_drop: got %b expected 0", bd); end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] res; bit tmo, bd, bad; int nd;
    int seen = 0; bit found = 1'b0; int stray = 0;
    lat_max = 6;
    @(negedge clk);
    bus.N_i = 33; bus.y_i = 2; bus.d_i = 7; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (bus.mm_start === 1'b1) seen++;
      if (seen == 2) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL midrst_reach_sqr: got %b expected 1", found); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %b expected 0", bus.done); end
    checks++; if (bus.result !== '0) begin failures++; $display("FAIL midrst_result: got %0h expected 0", bus.result); end
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.mm_start !== 1'b0 || bus.pp_start !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) stray++;
    end
    checks++; if (stray !== 0) begin failures++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", stray); end
    do_run(33, 2, 7, 6, -1, -1, res, tmo, bd, bad, nd);
    checks++; if (res !== WIDTH'(29)) begin failures++; $display("FAIL midrst_rerun_result: got %0h expected 1d", res); end
  endtask

  task automatic test_spurious_finish();
    logic [WIDTH-1:0] res; bit tmo, bd, bad; int nd;
    do_run(33, 3, 5, 6, -1, 0, res, tmo, bd, bad, nd);
    checks++; if (res !== WIDTH'(12)) begin failures++; $display("FAIL spurious_result: got %0h expected c", res); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL spurious_done_count: got %0d expected 1", nd); end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] res, n, y, d, expv; bit tmo, bd, bad; int nd;
    for (int s = 0; s < 20; s++) begin
      for (int k = 0; k < WIDTH / 32; k++) begin
        n[k*32 +: 32] = $urandom;
        y[k*32 +: 32] = $urandom;
        d[k*32 +: 32] = $urandom;
      end
      n[0]       = 1'b1;
      n[WIDTH-1] = 1'b1;
      y[WIDTH-1] = 1'b0;
      expv = modexp(y, d, n);
      do_run(n, y, d, 4, -1, -1, res, tmo, bd, bad, nd);
      checks++;
      if (tmo !== 1'b0 || res !== expv) begin
        failures++;
        $display("FAIL random_%0d: got %0h expected %0h", s, res, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_exponents();
    test_restart_ignored();
    test_reset_mid();
    test_spurious_finish();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
